// File: rtl/ws_chain_ctrl_pkg.sv
// Shared types and 100 MHz timing defaults for the WS281x-style LED chain controller.
// Pure declarations: no latency, no backpressure.
package ws_pkg;

    typedef enum logic [1:0] {
        RET  = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2,
        BIT  = 2'd3
    } wsState_t;

    // 10 ns clk: 0.4 us / 0.8 us high, 1.25 us bit, 50 us latch
    localparam int DEF_NUM_LEDS     = 8;
    localparam int DEF_BITS_PER_LED = 24;
    localparam int DEF_T0H          = 40;
    localparam int DEF_T1H          = 80;
    localparam int DEF_TBIT         = 125;
    localparam int DEF_TRET         = 5000;

    function automatic int cntWidth(input int range);
        return (range <= 1) ? 1 : $clog2(range);
    endfunction

endpackage

// File: rtl/ws_chain_ctrl_if.sv
// Pixel word stream into the chain controller (valid/ready).
// Wires only: no latency; the slave throttles the source with pix_ready.
interface ws_chain_ctrl_if #(
    parameter int BITS_PER_LED = 24
);
    logic                    pix_valid;
    logic [BITS_PER_LED-1:0] pix_data;
    logic                    pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/ws_bit_gen.sv
// One bit period of the serial line: dout high for T0H/T1H cycles of a TBIT-cycle period.
// start begins a period on the next cycle (no gap); period_done flags the final cycle; no backpressure.
module ws_bit_gen
    import ws_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bitVal,
    output logic dout,
    output logic period_done
);
    localparam int PW = cntWidth(TBIT);
    localparam logic [PW-1:0] PH_LAST  = PW'(TBIT - 1);
    localparam logic [PW-1:0] HI0_LAST = PW'(T0H - 1);
    localparam logic [PW-1:0] HI1_LAST = PW'(T1H - 1);

    logic [PW-1:0] phase;
    logic          active;

    // dout is registered, so it is decided from the phase about to begin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase  <= '0;
            active <= 1'b0;
            dout   <= 1'b0;
        end else if (start) begin
            phase  <= '0;
            active <= 1'b1;
            dout   <= 1'b1;
        end else if (active) begin
            if (phase == PH_LAST) begin
                phase  <= '0;
                active <= 1'b0;
                dout   <= 1'b0;
            end else begin
                phase <= phase + 1'b1;
                dout  <= (phase < (bitVal ? HI1_LAST : HI0_LAST));
            end
        end
    end

    assign period_done = active && (phase == PH_LAST);

endmodule

// File: rtl/ws_chain_ctrl.sv
// Frame sequencer for an LED chain: RET latch, WAIT for go (WS_AUTO_REFRESH_EN: restart unconditionally), LOAD a pixel, BIT it out MSB first.
// Bit timing fixed by parameters; a LOAD stalls indefinitely on pix_valid=0 with dout held low.
module ws_chain_ctrl
    import ws_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int BITS_PER_LED = DEF_BITS_PER_LED,
    parameter int T0H          = DEF_T0H,
    parameter int T1H          = DEF_T1H,
    parameter int TBIT         = DEF_TBIT,
    parameter int TRET         = DEF_TRET
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            go,
    ws_chain_ctrl_if.slave                  pix,
    output logic                            dout,
    output logic                            busy,
    output logic                            frame_done,
    output logic [cntWidth(NUM_LEDS)-1:0]   led_index
);
    localparam int RW = cntWidth(TRET);
    localparam int BW = cntWidth(BITS_PER_LED);
    localparam int LW = cntWidth(NUM_LEDS);
    localparam logic [RW-1:0] RET_LAST = RW'(TRET - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_LED - 1);
    localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS - 1);

    wsState_t                state;
    wsState_t                nextState;
    logic [RW-1:0]           retCnt;
    logic [BW-1:0]           bitCnt;
    logic [BITS_PER_LED-1:0] shiftReg;
    logic                    xfer;
    logic                    bitStart;
    logic                    frameEnd;
    logic                    periodDone;
    logic                    lastBit;
    logic                    lastLed;

    assign lastBit = (bitCnt == BIT_LAST);
    assign lastLed = (led_index == LED_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RET;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        xfer      = 1'b0;
        bitStart  = 1'b0;
        frameEnd  = 1'b0;
        case (state)
            RET: begin
                if (retCnt == RET_LAST) nextState = WAIT;
            end
            WAIT: begin
`ifdef WS_AUTO_REFRESH_EN
                nextState = LOAD;
`else
                if (go) nextState = LOAD;
`endif
            end
            LOAD: begin
                if (pix.pix_valid) begin
                    xfer      = 1'b1;
                    bitStart  = 1'b1;
                    nextState = BIT;
                end
            end
            BIT: begin
                // next bit of the same LED starts straight away, no gap cycle
                if (periodDone) begin
                    if (!lastBit) begin
                        bitStart = 1'b1;
                    end else if (!lastLed) begin
                        nextState = LOAD;
                    end else begin
                        nextState = RET;
                        frameEnd  = 1'b1;
                    end
                end
            end
            default: nextState = RET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retCnt     <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            led_index  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frameEnd;
            if ((state == RET) && (retCnt != RET_LAST)) retCnt <= retCnt + 1'b1;
            else                                         retCnt <= '0;
            if (state == WAIT) led_index <= '0;
            if (xfer) begin
                shiftReg <= pix.pix_data;
                bitCnt   <= '0;
            end else if ((state == BIT) && periodDone) begin
                if (!lastBit) begin
                    shiftReg <= shiftReg << 1;
                    bitCnt   <= bitCnt + 1'b1;
                end else if (!lastLed) begin
                    led_index <= led_index + 1'b1;
                end
            end
        end
    end

    assign busy          = (state == LOAD) || (state == BIT);
    assign pix.pix_ready = (state == LOAD);

    ws_bit_gen #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_gen (
        .clk         (clk),
        .reset       (reset),
        .start       (bitStart),
        .bitVal      (shiftReg[BITS_PER_LED-1]),
        .dout        (dout),
        .period_done (periodDone)
    );

endmodule

// File: tb/tb_ws_chain_ctrl.sv
// Bench for ws_chain_ctrl: decodes dout into high-times and period gaps and compares with a per-bit model.
// Build with WS_AUTO_REFRESH_EN defined to exercise continuous refresh instead of go-started frames.
module tb_ws_chain_ctrl;
    localparam int NL     = 2;
    localparam int BPL    = 24;
    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TRET   = 10;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       dout;
    logic       busy;
    logic       frame_done;
    logic [0:0] led_index;

    ws_chain_ctrl_if #(.BITS_PER_LED(BPL)) pixIf ();

    ws_chain_ctrl #(
        .NUM_LEDS(NL), .BITS_PER_LED(BPL), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRET(TRET)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .pix        (pixIf),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .led_index  (led_index)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [BPL-1:0] words [NL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // high time of serial bit i of the frame, LED-major, MSB first
    function automatic int expHigh(input int i);
        int led;
        int b;
        led = i / BPL;
        b   = BPL - 1 - (i % BPL);
        return words[led][b] ? T1H : T0H;
    endfunction

    // rising edge of bit i minus rising edge of bit i-1
    function automatic int expGap(input int i, input int stall);
        if ((i % BPL) != 0) return TBIT;
        return TBIT + 1 + (((i / BPL) == 1) ? stall : 0);
    endfunction

    task automatic randomize_words();
        for (int i = 0; i < NL; i++) words[i] = BPL'($urandom);
    endtask

    task automatic run_frame(input int stall, input int abortBit, output bit aborted);
        int k, stallCnt, cyc, rises, highRun, lastRise, doneCnt, firstReady;
        bit prev;
        int highs[$];
        int gaps[$];
        k = 0; stallCnt = 0; cyc = 0; rises = 0; highRun = 0;
        lastRise = -1; doneCnt = 0; firstReady = -1; prev = 1'b0; aborted = 1'b0;
        go = 1'b1;
        while (doneCnt == 0 && !aborted && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (busy) go = 1'b0;
            if (dout && !prev) begin
                rises++;
                if (lastRise >= 0) gaps.push_back(cyc - lastRise);
                lastRise = cyc;
                highRun  = 1;
                if (abortBit >= 0 && rises == abortBit + 1) aborted = 1'b1;
            end else if (dout) begin
                highRun++;
            end else if (prev) begin
                highs.push_back(highRun);
            end
            prev = dout;
            if (frame_done) doneCnt++;
            if (!aborted) begin
                if (pixIf.pix_ready) begin
                    if (firstReady < 0) firstReady = cyc;
                    if (k == 1 && stallCnt < stall) begin
                        if (stallCnt == 0) chk("stall_led_index", 32'(led_index), 1);
                        chk("stall_dout", 32'(dout), 0);
                        pixIf.pix_valid = 1'b0;
                        stallCnt++;
                    end else begin
                        chk("load_led_index", 32'(led_index), k);
                        pixIf.pix_valid = 1'b1;
                        pixIf.pix_data  = (k < NL) ? words[k] : '0;
                        k++;
                    end
                end else begin
                    pixIf.pix_valid = 1'($urandom_range(0, 1));
                    pixIf.pix_data  = BPL'($urandom);
                end
            end
        end
        pixIf.pix_valid = 1'b0;
        chk("ready_latency", firstReady, 1);
        if (!aborted) begin
            chk("frame_done_seen", doneCnt, 1);
            chk("busy_after_frame", 32'(busy), 0);
            chk("dout_after_frame", 32'(dout), 0);
            chk("bit_count", highs.size(), NL * BPL);
            for (int i = 0; i < highs.size() && i < NL * BPL; i++)
                chk($sformatf("bit%0d_high", i), highs[i], expHigh(i));
            for (int i = 0; i < gaps.size() && i < NL * BPL - 1; i++)
                chk($sformatf("bit%0d_gap", i + 1), gaps[i], expGap(i + 1, stall));
        end
    endtask

    // a full RET then one WAIT cycle before a held go reaches LOAD
    task automatic measure_ret(input string tag);
        int n;
        int fd;
        n = 0; fd = 0;
        go = 1'b1;
        pixIf.pix_valid = 1'b0;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (frame_done) fd++;
            if (pixIf.pix_ready) break;
        end
        chk({tag, "_latency"}, n, TRET + 1);
        chk({tag, "_extra_done"}, fd, 0);
        go = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dout"}, 32'(dout), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ready"}, 32'(pixIf.pix_ready), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_led_index"}, 32'(led_index), 0);
    endtask

    initial begin
        bit ab;
        reset = 1'b1;
        go = 1'b0;
        pixIf.pix_valid = 1'b0;
        pixIf.pix_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
`ifdef WS_AUTO_REFRESH_EN
        begin
            int n;
            int last;
            int dones;
            n = 0; last = 0; dones = 0;
            reset = 1'b0;
            pixIf.pix_valid = 1'b1;
            while (dones < 5 && n < 4 * BUDGET) begin
                @(negedge clk);
                n++;
                pixIf.pix_data = BPL'($urandom);
                if (frame_done) begin
                    chk($sformatf("refresh_period%0d", dones), n - last, NL * BPL * TBIT + TRET + 1 + NL);
                    last = n;
                    dones++;
                end
            end
            chk("refresh_frames", dones, 5);
        end
`else
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("idle_dout", 32'(dout), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        words[0] = 24'hA50000;
        words[1] = 24'h000001;
        run_frame(0, -1, ab);
        measure_ret("ret_directed");

        randomize_words();
        run_frame(20, -1, ab);
        measure_ret("ret_stall");

        for (int f = 0; f < 3; f++) begin
            randomize_words();
            run_frame($urandom_range(0, 5), -1, ab);
            measure_ret("ret_random");
        end

        randomize_words();
        run_frame(0, 7, ab);
        chk("abort_reached", 32'(ab), 1);
        reset = 1'b1;
        #1;
        check_reset_state("midframe_reset");
        @(negedge clk);
        reset = 1'b0;
        measure_ret("ret_after_reset");

        randomize_words();
        run_frame(0, -1, ab);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
